// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB transfer/response encodings and response-mux FSM states
package ahb_pkg;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_TO_ERR1, S_TO_ERR2} mux_state_t;
endpackage

// File: rtl/ahb_wait_timer.sv
// ahb_wait_timer: saturating wait-state counter with clear and expiry compare
module ahb_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic h_clk,
  input  logic h_resetn,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge h_clk) begin
    if (!h_resetn || clr) cnt <= '0;
    else if (inc && cnt != LAST) cnt <= cnt + CW'(1);
  end
  assign expired = cnt == LAST;
endmodule

// File: rtl/ahb_slave_mux.sv
// ahb_slave_mux: routes the data-phase slave response to the master, with a
// wait-state watchdog that turns a stalled transfer into a two-cycle ERROR.
module ahb_slave_mux
  import ahb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      h_clk,
  input  logic                      h_resetn,
  input  logic [NUM_SLV-1:0]        h_sel,
  input  logic [1:0]                h_trans,
  input  logic [NUM_SLV-1:0]        h_ready_s,
  input  logic [NUM_SLV-1:0]        h_resp_s,
  input  logic [NUM_SLV*DATA_W-1:0] h_rdata_s,
  input  logic                      h_ready_def,
  input  logic                      h_resp_def,
  output logic                      h_ready,
  output logic                      h_resp,
  output logic [DATA_W-1:0]         h_rdata,
  output logic                      timeout_flag
);
  localparam int SW = $clog2(NUM_SLV + 1);
  mux_state_t state, nxt;
  logic [SW-1:0] dp_sel, sel_idx;
  logic dp_valid, cap_valid, act, r_rdy, r_resp, expired;
  logic [DATA_W-1:0] r_data;
  // Lowest set bit wins on an illegal multi-hot select; none set is the default slot.
  always_comb begin
    sel_idx = SW'(NUM_SLV);
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if (h_sel[i]) sel_idx = SW'(i);
  end
  assign cap_valid = h_trans == NONSEQ || h_trans == SEQ;
  assign act = state == S_ACTIVE && dp_valid;
  always_comb begin
    r_rdy  = h_ready_def;
    r_resp = h_resp_def;
    r_data = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (dp_sel == SW'(i)) begin
        r_rdy  = h_ready_s[i];
        r_resp = h_resp_s[i];
        r_data = h_rdata_s[i*DATA_W +: DATA_W];
      end
  end
  always_comb begin
    h_ready      = act ? r_rdy : state != S_TO_ERR1;
    h_resp       = act ? r_resp : (state == S_TO_ERR1 || state == S_TO_ERR2) ? ERROR : OKAY;
    h_rdata      = act ? r_data : '0;
    timeout_flag = act && !r_rdy && expired;
    nxt          = state == S_TO_ERR1 ? S_TO_ERR2 :
                   timeout_flag ? S_TO_ERR1 :
                   h_ready ? (cap_valid ? S_ACTIVE : S_IDLE) : state;
  end
  always_ff @(posedge h_clk) begin
    if (!h_resetn) begin
      state    <= S_IDLE;
      dp_valid <= 1'b0;
      dp_sel   <= SW'(NUM_SLV);
    end else begin
      state <= nxt;
      if (h_ready) begin
        dp_sel   <= sel_idx;
        dp_valid <= cap_valid;
      end
    end
  end
  ahb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .h_clk    (h_clk),
    .h_resetn (h_resetn),
    .clr      (!act || r_rdy || expired),
    .inc      (!r_rdy),
    .expired  (expired)
  );
endmodule
